// File: rtl/data_mem_responder_pkg.sv
// Shared memory-control encodings for the decoder and the MEM-stage data memory responder.
// Holds the SIZE and RW field values plus the responder state enum.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // The reserved size reports 4 bytes; it is always flagged as an error anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// Big-endian lane logic: byte enables, store-data steering, load extraction/extension
// and access error detection for one byte-addressed word-organised RAM access.
module mem_lane_align
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 512
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        se,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_data,
  output logic        err
);

  logic [1:0]  off;
  logic [32:0] end_addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // byte_en[i] enables byte offset i within the word, which lives in rword bits [31-8i -: 8].
  always_comb begin
    off       = addr[1:0];
    end_addr  = {1'b0, addr} + {30'd0, size_bytes(size)};
    err       = 1'b0;
    byte_en   = 4'b0000;
    wword     = 32'd0;
    load_data = 32'd0;
    byte_sel  = 8'd0;
    half_sel  = off[1] ? rword[15:0] : rword[31:16];

    case (off)
      2'd0:    byte_sel = rword[31:24];
      2'd1:    byte_sel = rword[23:16];
      2'd2:    byte_sel = rword[15:8];
      default: byte_sel = rword[7:0];
    endcase

    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << off;
        wword     = {4{wdata[7:0]}};
        load_data = se ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      SZ_HALF: begin
        err       = addr[0];
        byte_en   = off[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wdata[15:0]}};
        load_data = se ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      SZ_WORD: begin
        err       = (off != 2'd0);
        byte_en   = 4'b1111;
        wword     = wdata;
        load_data = rword;
      end
      default: err = 1'b1;
    endcase

    if (end_addr > 33'(DEPTH_BYTES)) err = 1'b1;

    if (err) begin
      byte_en   = 4'b0000;
      load_data = 32'd0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one request in flight, fixed access latency,
// big-endian byte-addressed RAM with load extension and access error reporting.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        E,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SE,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept, enter_resp;
  logic        rw_q, se_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        a_rw, a_se;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic [31:0] rword, wword, load_data;
  logic [3:0]  byte_en;
  logic        lane_err;
  logic [7:0]  mem [DEPTH_BYTES];

  assign accept     = req_valid && E && (state == IDLE);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign enter_resp = (state_next == RESP) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q    <= RW_LOAD;
      se_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      rw_q    <= RW;
      se_q    <= SE;
      size_q  <= SIZE;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // With zero latency the access happens on the acceptance edge, before the capture registers load.
  always_comb begin
    if (state == IDLE) begin
      a_rw    = RW;
      a_se    = SE;
      a_size  = SIZE;
      a_addr  = addr;
      a_wdata = wdata;
    end else begin
      a_rw    = rw_q;
      a_se    = se_q;
      a_size  = size_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  assign rword = {mem[{a_addr[AW-1:2], 2'd0}], mem[{a_addr[AW-1:2], 2'd1}],
                  mem[{a_addr[AW-1:2], 2'd2}], mem[{a_addr[AW-1:2], 2'd3}]};

  mem_lane_align #(.DEPTH_BYTES(DEPTH_BYTES)) u_align (
    .addr      (a_addr),
    .size      (a_size),
    .se        (a_se),
    .wdata     (a_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wword     (wword),
    .load_data (load_data),
    .err       (lane_err)
  );

  always_ff @(posedge clk) begin
    if (enter_resp && (a_rw == RW_STORE)) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[{a_addr[AW-1:2], 2'(i)}] <= wword[8*(3-i) +: 8];
      end
    end
  end

  // rdata and rsp_err only carry a value during the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= 32'd0;
      rsp_err <= 1'b0;
    end else if (enter_resp) begin
      rdata   <= (a_rw == RW_LOAD) ? load_data : 32'd0;
      rsp_err <= lane_err;
    end else begin
      rdata   <= 32'd0;
      rsp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed requests, a byte-level memory model
// compared every cycle, and a zero-latency instance for the handshake pattern.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, E = 1'b0, RW = 1'b0, SE = 1'b0;
  logic [1:0]  SIZE = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rdata;

  logic        h_req_valid = 1'b0, h_E = 1'b0, h_RW = 1'b1;
  logic [31:0] h_addr = 32'h40, h_wdata = 32'h5A5AC3C3;
  logic        h_req_ready, h_rsp_valid, h_rsp_err;
  logic [31:0] h_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .E(E), .RW(RW), .SIZE(SIZE), .SE(SE), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(h_req_valid), .req_ready(h_req_ready),
    .E(h_E), .RW(h_RW), .SIZE(SZ_WORD), .SE(1'b0), .addr(h_addr), .wdata(h_wdata),
    .rsp_valid(h_rsp_valid), .rdata(h_rdata), .rsp_err(h_rsp_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model of the main instance: byte memory plus the cycle at which the pending request answers.
  logic [7:0]  model_mem [DEPTH];
  int          cyc = 0, due = 0;
  bit          pend = 1'b0;
  logic        m_rw = 1'b0, m_se = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
  bit          exp_ready = 1'b1, exp_valid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'd0;

  task automatic model_access();
    int n, base;
    longint a;
    logic [31:0] v;
    n = (m_size == SZ_BYTE) ? 1 : (m_size == SZ_HALF) ? 2 : 4;
    a = longint'(m_addr);
    exp_err   = (m_size == SZ_RSVD) || ((a % n) != 0) || ((a + n) > DEPTH);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      base = int'(a);
      if (m_rw) begin
        for (int i = 0; i < n; i++) model_mem[base + i] = 8'(m_wdata >> (8 * (n - 1 - i)));
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, model_mem[base + i]};
        if (m_se && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        exp_rdata = v;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 1'b0; exp_ready = 1'b1; exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
    end else begin
      if (exp_ready && req_valid && E) begin
        m_rw = RW; m_se = SE; m_size = SIZE; m_addr = addr; m_wdata = wdata;
        pend = 1'b1;
        due  = cyc + LAT;
      end
      exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
      if (pend && cyc == due) begin
        model_access();
        exp_valid = 1'b1;
        pend      = 1'b0;
      end
      exp_ready = !pend && !exp_valid;
      cyc++;
    end
  end

  always @(negedge clk) begin
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
      checkOutput("rdata", rdata, exp_rdata);
    end
  end

  task automatic applyStimulus(input logic rw, input logic [1:0] size, input logic se,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output logic err, output int lat);
    int k;
    rd = 32'd0; err = 1'b0; lat = 0;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL ready_timeout: req_ready stuck at 0, expected 1");
      return;
    end
    req_valid = 1'b1; E = 1'b1; RW = rw; SIZE = size; SE = se; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; E = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'd0;
    lat = 1; k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; lat++; end
    if (!rsp_valid) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL rsp_timeout: rsp_valid stuck at 0, expected 1");
      return;
    end
    rd  = rdata;
    err = rsp_err;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    applyStimulus(RW_STORE, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checkOutput("st_word_latency", 32'(lat), 32'd3);
    checkOutput("st_word_err", 32'(er), 32'd0);
    checkOutput("st_word_rdata", rd, 32'd0);
    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h10, 32'd0, rd, er, lat);
    checkOutput("ld_word_0x10", rd, 32'hDEADBEEF);

    // A request with E=0 must be ignored completely.
    @(negedge clk);
    req_valid = 1'b1; E = 1'b0; RW = RW_STORE; SIZE = SZ_WORD; addr = 32'h10; wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("e0_ready", 32'(req_ready), 32'd1);
      checkOutput("e0_valid", 32'(rsp_valid), 32'd0);
    end
    req_valid = 1'b0;
    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h10, 32'd0, rd, er, lat);
    checkOutput("e0_no_write", rd, 32'hDEADBEEF);

    applyStimulus(RW_LOAD, SZ_BYTE, 1'b0, 32'h10, 32'd0, rd, er, lat);
    checkOutput("ldub_0x10", rd, 32'h000000DE);
    applyStimulus(RW_LOAD, SZ_BYTE, 1'b1, 32'h10, 32'd0, rd, er, lat);
    checkOutput("ldsb_0x10", rd, 32'hFFFFFFDE);
    applyStimulus(RW_LOAD, SZ_BYTE, 1'b0, 32'h13, 32'd0, rd, er, lat);
    checkOutput("ldub_0x13", rd, 32'h000000EF);

    applyStimulus(RW_STORE, SZ_HALF, 1'b0, 32'h20, 32'hFFFF1234, rd, er, lat);
    applyStimulus(RW_LOAD, SZ_HALF, 1'b0, 32'h20, 32'd0, rd, er, lat);
    checkOutput("lduh_0x20", rd, 32'h00001234);
    applyStimulus(RW_STORE, SZ_HALF, 1'b0, 32'h22, 32'h00008001, rd, er, lat);
    applyStimulus(RW_LOAD, SZ_HALF, 1'b1, 32'h22, 32'd0, rd, er, lat);
    checkOutput("ldsh_0x22", rd, 32'hFFFF8001);
    applyStimulus(RW_STORE, SZ_BYTE, 1'b0, 32'h21, 32'h0000007F, rd, er, lat);
    applyStimulus(RW_LOAD, SZ_HALF, 1'b0, 32'h20, 32'd0, rd, er, lat);
    checkOutput("lduh_after_stb", rd, 32'h0000127F);

    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h11, 32'd0, rd, er, lat);
    checkOutput("lw_misaligned_err", 32'(er), 32'd1);
    checkOutput("lw_misaligned_rdata", rd, 32'd0);
    applyStimulus(RW_STORE, SZ_HALF, 1'b0, 32'h21, 32'h0000BEEF, rd, er, lat);
    checkOutput("sth_misaligned_err", 32'(er), 32'd1);
    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h20, 32'd0, rd, er, lat);
    checkOutput("word_0x20_unchanged", rd, 32'h127F8001);
    applyStimulus(RW_LOAD, SZ_RSVD, 1'b0, 32'h20, 32'd0, rd, er, lat);
    checkOutput("size_rsvd_err", 32'(er), 32'd1);
    checkOutput("size_rsvd_rdata", rd, 32'd0);

    applyStimulus(RW_STORE, SZ_WORD, 1'b0, 32'h1FC, 32'hCAFEF00D, rd, er, lat);
    checkOutput("st_last_word_err", 32'(er), 32'd0);
    applyStimulus(RW_LOAD, SZ_BYTE, 1'b0, 32'h1FF, 32'd0, rd, er, lat);
    checkOutput("ldub_last_byte", rd, 32'h0000000D);
    applyStimulus(RW_LOAD, SZ_HALF, 1'b1, 32'h1FE, 32'd0, rd, er, lat);
    checkOutput("ldsh_last_half", rd, 32'hFFFFF00D);
    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h1FE, 32'd0, rd, er, lat);
    checkOutput("lw_0x1FE_err", 32'(er), 32'd1);
    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h200, 32'd0, rd, er, lat);
    checkOutput("lw_0x200_range_err", 32'(er), 32'd1);

    // Abort a store with reset while it is still waiting.
    applyStimulus(RW_STORE, SZ_WORD, 1'b0, 32'h30, 32'h11111111, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; E = 1'b1; RW = RW_STORE; SIZE = SZ_WORD; SE = 1'b0;
    addr = 32'h30; wdata = 32'hAAAAAAAA;
    @(negedge clk);
    req_valid = 1'b0; E = 1'b0;
    checkOutput("abort_busy", 32'(req_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rdata", rdata, 32'd0);
    checkOutput("abort_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(RW_LOAD, SZ_WORD, 1'b0, 32'h30, 32'd0, rd, er, lat);
    checkOutput("abort_store_discarded", rd, 32'h11111111);

    // Zero-latency instance with req_valid held high: accepts every other cycle.
    @(negedge clk);
    h_req_valid = 1'b1; h_E = 1'b1; h_RW = RW_STORE;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("l0_ready", 32'(h_req_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("l0_valid", 32'(h_rsp_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) checkOutput("l0_err", 32'(h_rsp_err), 32'd0);
    end
    h_RW = RW_LOAD;
    @(negedge clk);
    h_req_valid = 1'b0;
    checkOutput("l0_load_valid", 32'(h_rsp_valid), 32'd1);
    checkOutput("l0_load_rdata", h_rdata, 32'h5A5AC3C3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
